fix_session_ctrl: RTL and testbench
===================================

Name: fix_session_ctrl

Overview:
- Connection sequencer between the application API and the TOE for the FIX engine's session layer.
- Accepts connect and disconnect commands for up to 4 hosts (2-bit address) and issues connect-request pulses to the TOE.
- Waits for the TOE connected acknowledge, retrying after a timeout up to a fixed limit; tracks per-host connected state.
- Feeds the connect_req_o/connect_addr_o and disconnect_o/disconnect_host_num_o path into the outbound FIFO.

Parameters:
- TIMEOUT_CYC, 64, cycles to wait in WAIT_ACK for a matching acknowledge; legal range 2..65535.
- MAX_RETRY, 3, number of re-requests after the first attempt before declaring failure; 0 means a single attempt.
- GAP_CYC, 8, idle cycles between a timeout and the next request; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- connect_i  in  1  app connect command, level-sampled in IDLE.
- connect_to_host_i  in  2  app target host.
- disconnect_i  in  1  app disconnect command, level-sampled in IDLE.
- disconnect_host_i  in  2  app host to tear down.
- connected_i  in  1  TOE acknowledge, 1-cycle pulse.
- connected_host_addr_i  in  2  host being acknowledged, valid with connected_i.
- connect_req_o  out  1  1-cycle request pulse to the FIFO.
- connect_addr_o  out  2  host for connect_req_o; holds the last value otherwise.
- disconnect_o  out  1  1-cycle disconnect pulse to the FIFO.
- disconnect_host_num_o  out  2  host for disconnect_o; holds the last value otherwise.
- host_connected_o  out  4  per-host connected flags.
- busy_o  out  1  high whenever state is not IDLE.
- connect_done_o  out  1  1-cycle pulse when a connect command completes.
- connect_fail_o  out  1  1-cycle pulse when retries are exhausted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, addresses 00, host_connected_o=0000. Retry and timeout counters cleared. Asserting reset mid-transaction aborts it with no done or fail pulse.
- States: IDLE, REQ, WAIT_ACK, GAP.
- IDLE, disconnect_i=1 (priority over connect_i):
  - next cycle: disconnect_o=1, disconnect_host_num_o=disconnect_host_i, bit cleared in host_connected_o.
  - remain IDLE; connect_i is ignored that cycle.
  - disconnecting an unconnected host still pulses disconnect_o.
- IDLE, connect_i=1, target bit already set: connect_done_o pulses next cycle, no request issued, remain IDLE.
- IDLE, connect_i=1, target bit clear: latch the host, retry_cnt=0, go to REQ.
- REQ (1 cycle): connect_req_o=1, connect_addr_o=latched host; load timeout counter; go to WAIT_ACK.
- WAIT_ACK, matching acknowledge (connected_i=1 with connected_host_addr_i equal to the latched host):
  - set the host bit, pulse connect_done_o next cycle, go to IDLE.
  - an acknowledge arriving in the REQ cycle is also accepted, finishing one cycle after WAIT_ACK entry.
- WAIT_ACK timeout: after TIMEOUT_CYC cycles without a match:
  - if retry_cnt<MAX_RETRY, increment retry_cnt and go to GAP.
  - otherwise pulse connect_fail_o and go to IDLE.
- GAP: count GAP_CYC cycles, then go to REQ.
- Unsolicited acknowledge: connected_i for a non-latched host, in any state, sets that host's bit. It does not affect the FSM or pulse done.
- Same-cycle events: disconnect command and acknowledge for the same host in IDLE → disconnect wins, bit ends cleared.
- Commands arriving while busy_o=1 are ignored; the app holds them until busy_o=0.
- Counter widths: timeout 16 bit, gap 8 bit, retry 8 bit; no wrap-around is reachable within legal parameter ranges.
- Total request pulses per command = MAX_RETRY+1 maximum.

Test Plan:
- Reset release, connect_i=1, host=00, TOE acks host 00 two cycles after the request → one connect_req_o with addr 00; connect_done_o pulses; host_connected_o=0001; busy_o low again.
- Connect to host 10 with no ack, defaults → requests at intervals of 64+8+1 cycles, 4 in total; connect_fail_o after the 4th timeout; host_connected_o unchanged.
- Host 01 connected, then disconnect_i with host 01 → disconnect_o pulse, disconnect_host_num_o=01, host_connected_o=0000.
- connect_i and disconnect_i asserted together in IDLE → only disconnect_o pulses; connect is processed the following cycle once disconnect_i drops.
- Waiting on host 11 and the TOE acks host 00 → host_connected_o bit 0 set; the FSM keeps waiting; a later ack for 11 completes with done.
- rst pulled low during GAP on the 2nd retry → all outputs 0 immediately; no further request or fail pulse after release.

Source files
------------

// File: rtl/fix_session_ctrl.sv
// Session-layer connection sequencer: turns app connect/disconnect commands into
// TOE request pulses, retries on acknowledge timeout and tracks per-host connected flags.
module fix_session_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_RETRY   = 3,
  parameter int GAP_CYC     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connect_i,
  input  logic [1:0] connect_to_host_i,
  input  logic       disconnect_i,
  input  logic [1:0] disconnect_host_i,
  input  logic       connected_i,
  input  logic [1:0] connected_host_addr_i,
  output logic       connect_req_o,
  output logic [1:0] connect_addr_o,
  output logic       disconnect_o,
  output logic [1:0] disconnect_host_num_o,
  output logic [3:0] host_connected_o,
  output logic       busy_o,
  output logic       connect_done_o,
  output logic       connect_fail_o,
  output logic [1:0] dbg_state_o
);

  // Handshake: connect_i/disconnect_i are levels sampled only while busy_o is low
  // (the app holds them until then); every *_o pulse is a one-cycle strobe with no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_GAP      = 2'd3
  } state_e;

  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [1:0]  host_q, host_d;
  logic        req_q, req_d;
  logic        disc_q, disc_d;
  logic [1:0]  disc_host_q, disc_host_d;
  logic [3:0]  hc_q, hc_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  retry_q, retry_d;
  logic        ack_pend_q, ack_pend_d;
  logic        ack_match;

  assign ack_match = connected_i && (connected_host_addr_i == host_q);

  always_comb begin
    state_d     = state_q;
    host_d      = host_q;
    req_d       = 1'b0;
    disc_d      = 1'b0;
    disc_host_d = disc_host_q;
    hc_d        = hc_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    retry_d     = retry_q;
    ack_pend_d  = ack_pend_q;

    // Any acknowledge marks its host connected; an IDLE disconnect below overrides it.
    if (connected_i) begin
      hc_d[connected_host_addr_i] = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        ack_pend_d = 1'b0;
        if (disconnect_i) begin
          disc_d                 = 1'b1;
          disc_host_d            = disconnect_host_i;
          hc_d[disconnect_host_i] = 1'b0;
        end else if (connect_i) begin
          if (hc_q[connect_to_host_i]) begin
            done_d = 1'b1;
          end else begin
            host_d  = connect_to_host_i;
            retry_d = 8'd0;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // An acknowledge landing in the request cycle is remembered and honoured in WAIT_ACK.
        tmo_d      = TMO_LOAD;
        ack_pend_d = ack_match;
        state_d    = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (ack_match || ack_pend_q) begin
          done_d       = 1'b1;
          ack_pend_d   = 1'b0;
          hc_d[host_q] = 1'b1;
          state_d      = S_IDLE;
        end else if (tmo_q == 16'd0) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end

      S_GAP: begin
        if (gap_q == 8'd0) begin
          req_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      host_q      <= 2'd0;
      req_q       <= 1'b0;
      disc_q      <= 1'b0;
      disc_host_q <= 2'd0;
      hc_q        <= 4'd0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 16'd0;
      gap_q       <= 8'd0;
      retry_q     <= 8'd0;
      ack_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      host_q      <= host_d;
      req_q       <= req_d;
      disc_q      <= disc_d;
      disc_host_q <= disc_host_d;
      hc_q        <= hc_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      retry_q     <= retry_d;
      ack_pend_q  <= ack_pend_d;
    end
  end

  assign connect_req_o         = req_q;
  assign connect_addr_o        = host_q;
  assign disconnect_o          = disc_q;
  assign disconnect_host_num_o = disc_host_q;
  assign host_connected_o      = hc_q;
  assign busy_o                = (state_q != S_IDLE);
  assign connect_done_o        = done_q;
  assign connect_fail_o        = fail_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_fix_session_ctrl.sv
// Bench for fix_session_ctrl: scenario tasks plus randomized connect/disconnect traffic,
// checked against a timeline model derived from the request/timeout/gap arithmetic.
module tb_fix_session_ctrl;

  localparam int TMO    = 64;
  localparam int MAXR   = 3;
  localparam int GAPC   = 8;
  localparam int PERIOD = TMO + GAPC + 1;

  logic       clk;
  logic       rst;
  logic       connect_i;
  logic [1:0] connect_to_host_i;
  logic       disconnect_i;
  logic [1:0] disconnect_host_i;
  logic       connected_i;
  logic [1:0] connected_host_addr_i;
  logic       connect_req_o;
  logic [1:0] connect_addr_o;
  logic       disconnect_o;
  logic [1:0] disconnect_host_num_o;
  logic [3:0] host_connected_o;
  logic       busy_o;
  logic       connect_done_o;
  logic       connect_fail_o;
  logic [1:0] dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [3:0] model_hc;

  fix_session_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .GAP_CYC(GAPC)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .connect_i             (connect_i),
    .connect_to_host_i     (connect_to_host_i),
    .disconnect_i          (disconnect_i),
    .disconnect_host_i     (disconnect_host_i),
    .connected_i           (connected_i),
    .connected_host_addr_i (connected_host_addr_i),
    .connect_req_o         (connect_req_o),
    .connect_addr_o        (connect_addr_o),
    .disconnect_o          (disconnect_o),
    .disconnect_host_num_o (disconnect_host_num_o),
    .host_connected_o      (host_connected_o),
    .busy_o                (busy_o),
    .connect_done_o        (connect_done_o),
    .connect_fail_o        (connect_fail_o),
    .dbg_state_o           (dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    logic [15:0] got;
    got = {connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
           host_connected_o, busy_o, connect_done_o, connect_fail_o, 3'b000};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL %s: outputs got %h expected 0000", name, got);
    end
  endtask

  // One connect command. ack_at: cycle offset (from first request pulse) of the TOE
  // acknowledge for h, -1 for none. u_at/u_host: unsolicited acknowledge, -1 for none.
  task automatic run_connect(input logic [1:0] h, input int ack_at,
                             input logic [1:0] u_host, input int u_at);
    logic [15:0] exp_q[$];
    int  end_cyc;
    bit  acked;
    bit  exp_req;
    connect_i         = 1'b1;
    connect_to_host_i = h;
    if (model_hc[h]) begin
      tick();
      connect_i = 1'b0;
      checks++;
      if (connect_done_o !== 1'b1 || connect_req_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL already_connected: done/req/busy got %b%b%b expected 100",
                 connect_done_o, connect_req_o, busy_o);
      end
      tick();
      checks++;
      if (connect_done_o !== 1'b0) begin
        errors++;
        $display("FAIL already_connected_drop: done got %b expected 0", connect_done_o);
      end
      return;
    end

    acked   = 1'b0;
    end_cyc = MAXR * PERIOD + TMO + 1;
    for (int i = 0; i <= MAXR; i++) begin
      exp_q.push_back(16'(i * PERIOD));
      if (ack_at >= i * PERIOD && ack_at <= i * PERIOD + TMO) begin
        acked   = 1'b1;
        end_cyc = (ack_at == i * PERIOD) ? ack_at + 2 : ack_at + 1;
        break;
      end
    end

    tick();
    connect_i = 1'b0;
    for (int c = 0; c <= end_cyc; c++) begin
      if (c > 0) tick();
      connected_i = 1'b0;
      exp_req = (exp_q.size() > 0 && int'(exp_q[0]) == c);
      if (exp_req) void'(exp_q.pop_front());
      checks++;
      if (connect_req_o !== exp_req) begin
        errors++;
        $display("FAIL conn_req host=%0d cyc=%0d: got %b expected %b", h, c, connect_req_o, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (connect_addr_o !== h) begin
          errors++;
          $display("FAIL conn_addr cyc=%0d: got %0d expected %0d", c, connect_addr_o, h);
        end
      end
      checks++;
      if (connect_done_o !== (acked && c == end_cyc) || connect_fail_o !== (!acked && c == end_cyc)) begin
        errors++;
        $display("FAIL done_fail host=%0d cyc=%0d: got %b%b expected %b%b", h, c,
                 connect_done_o, connect_fail_o, acked && c == end_cyc, !acked && c == end_cyc);
      end
      checks++;
      if (busy_o !== (c < end_cyc) || disconnect_o !== 1'b0) begin
        errors++;
        $display("FAIL busy cyc=%0d: busy/disc got %b%b expected %b0", c, busy_o, disconnect_o, c < end_cyc);
      end
      if (c == end_cyc) begin
        checks++;
        if (host_connected_o !== model_hc || connect_addr_o !== h) begin
          errors++;
          $display("FAIL conn_end_flags host=%0d: hc/addr got %b/%0d expected %b/%0d",
                   h, host_connected_o, connect_addr_o, model_hc, h);
        end
      end
      if (c == ack_at) begin
        connected_i = 1'b1;
        connected_host_addr_i = h;
        model_hc[h] = 1'b1;
      end else if (c == u_at) begin
        connected_i = 1'b1;
        connected_host_addr_i = u_host;
        model_hc[u_host] = 1'b1;
      end
    end
    connected_i = 1'b0;
    tick();
    checks++;
    if (connect_done_o !== 1'b0 || connect_fail_o !== 1'b0 || busy_o !== 1'b0 || connect_req_o !== 1'b0) begin
      errors++;
      $display("FAIL conn_after host=%0d: done/fail/busy/req got %b%b%b%b expected 0000",
               h, connect_done_o, connect_fail_o, busy_o, connect_req_o);
    end
  endtask

  // Disconnect h; ack_same also acknowledges h in the same cycle. Leaves connect_i alone.
  task automatic run_disconnect(input logic [1:0] h, input bit ack_same);
    disconnect_i      = 1'b1;
    disconnect_host_i = h;
    if (ack_same) begin
      connected_i           = 1'b1;
      connected_host_addr_i = h;
    end
    tick();
    disconnect_i = 1'b0;
    connected_i  = 1'b0;
    model_hc[h]  = 1'b0;
    checks++;
    if (disconnect_o !== 1'b1 || disconnect_host_num_o !== h || host_connected_o !== model_hc) begin
      errors++;
      $display("FAIL disconnect host=%0d: disc/num/hc got %b/%0d/%b expected 1/%0d/%b",
               h, disconnect_o, disconnect_host_num_o, host_connected_o, h, model_hc);
    end
    checks++;
    if (busy_o !== 1'b0 || connect_req_o !== 1'b0 || connect_done_o !== 1'b0) begin
      errors++;
      $display("FAIL disconnect_side host=%0d: busy/req/done got %b%b%b expected 000",
               h, busy_o, connect_req_o, connect_done_o);
    end
  endtask

  task automatic check_disc_dropped(input logic [1:0] h);
    tick();
    checks++;
    if (disconnect_o !== 1'b0 || disconnect_host_num_o !== h) begin
      errors++;
      $display("FAIL disc_drop: disc/num got %b/%0d expected 0/%0d", disconnect_o, disconnect_host_num_o, h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    connect_i = 1'b0; connect_to_host_i = 2'd0;
    disconnect_i = 1'b0; disconnect_host_i = 2'd0;
    connected_i = 1'b0; connected_host_addr_i = 2'd0;
    model_hc = 4'b0000;
    repeat (3) tick();
    check_all_zero("reset_hold");
    rst = 1'b1;
    tick();
    check_all_zero("reset_release");
  endtask

  task automatic test_basic_connect();
    run_connect(2'd0, 2, 2'd0, -1);
    checks++;
    if (host_connected_o !== 4'b0001) begin
      errors++;
      $display("FAIL basic_hc: got %b expected 0001", host_connected_o);
    end
  endtask

  task automatic test_timeout_fail();
    run_connect(2'd2, -1, 2'd0, -1);
  endtask

  task automatic test_disconnect();
    run_disconnect(2'd0, 1'b0);
    check_disc_dropped(2'd0);
    run_connect(2'd1, 7, 2'd0, -1);
    run_disconnect(2'd1, 1'b0);
    checks++;
    if (host_connected_o !== 4'b0000) begin
      errors++;
      $display("FAIL disconnect_hc: got %b expected 0000", host_connected_o);
    end
    check_disc_dropped(2'd1);
    run_disconnect(2'd3, 1'b0);
    check_disc_dropped(2'd3);
  endtask

  task automatic test_simultaneous();
    connect_i = 1'b1;
    connect_to_host_i = 2'd1;
    run_disconnect(2'd2, 1'b0);
    run_connect(2'd1, 4, 2'd0, -1);
  endtask

  task automatic test_unsolicited();
    run_connect(2'd3, 30, 2'd0, 5);
    checks++;
    if (host_connected_o !== 4'b1011) begin
      errors++;
      $display("FAIL unsolicited_hc: got %b expected 1011", host_connected_o);
    end
  endtask

  task automatic test_ack_windows();
    run_disconnect(2'd1, 1'b1);
    check_disc_dropped(2'd1);
    run_connect(2'd1, 0, 2'd0, -1);
    run_disconnect(2'd1, 1'b0);
    run_connect(2'd1, TMO, 2'd0, -1);
    run_disconnect(2'd1, 1'b0);
    run_connect(2'd1, PERIOD, 2'd0, -1);
    run_disconnect(2'd1, 1'b0);
    run_connect(2'd1, MAXR * PERIOD + TMO, 2'd2, 10);
    run_connect(2'd1, 3, 2'd0, -1);
  endtask

  task automatic test_random();
    logic [1:0] h;
    logic [1:0] u;
    int a;
    int ua;
    for (int it = 0; it < 10; it++) begin
      h = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        run_disconnect(h, 1'($urandom_range(0, 1)));
        check_disc_dropped(h);
      end else begin
        u  = h ^ 2'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) begin
          a  = -1;
          ua = $urandom_range(0, MAXR * PERIOD + TMO);
        end else begin
          a  = $urandom_range(0, MAXR) * PERIOD + $urandom_range(0, TMO);
          ua = (a > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, a - 1) : -1;
        end
        run_connect(h, a, u, ua);
      end
    end
  endtask

  task automatic test_reset_in_gap();
    bit exp_req;
    run_disconnect(2'd2, 1'b0);
    connect_i = 1'b1;
    connect_to_host_i = 2'd2;
    tick();
    connect_i = 1'b0;
    for (int c = 0; c < PERIOD + TMO + 3; c++) begin
      if (c > 0) tick();
      exp_req = (c == 0 || c == PERIOD);
      checks++;
      if (connect_req_o !== exp_req) begin
        errors++;
        $display("FAIL gap_req cyc=%0d: got %b expected %b", c, connect_req_o, exp_req);
      end
    end
    rst = 1'b0;
    model_hc = 4'b0000;
    #1;
    check_all_zero("reset_in_gap");
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4 * PERIOD; c++) begin
      tick();
      checks++;
      if (connect_req_o !== 1'b0 || connect_fail_o !== 1'b0 || connect_done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL after_reset cyc=%0d: req/fail/done/busy got %b%b%b%b expected 0000",
                 c, connect_req_o, connect_fail_o, connect_done_o, busy_o);
      end
    end
    check_all_zero("after_reset_final");
  endtask

  initial begin
    test_reset();
    test_basic_connect();
    test_timeout_fail();
    test_disconnect();
    test_simultaneous();
    test_unsolicited();
    test_ack_windows();
    test_random();
    test_reset_in_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
